// File: rtl/matrix_buffer.sv
// N x N matrix operand store: host word writes/reads, one-cycle bulk load, write map with lock when full.
// Latency: host read data and err are registered (1 cycle); mat_out is combinational from storage.
// Backpressure: none; illegal host accesses are dropped and flagged with a one-cycle err pulse.
//
// Ports: i_clk/i_rst (async, active-low); host bus i_sel, i_wr_en, i_rd_en, i_addr (byte address),
//        i_wr_data, o_rd_data, o_rd_valid; bulk path i_load_all, i_load_data; i_clear (sync wipe);
//        status o_mat_out, o_fill_cnt, o_ready, o_err.
module matrix_buffer #(
    parameter  int N      = 8,
    parameter  int BITS   = 8,
    parameter  int BUS_W  = 32,
    parameter  int ADDR_W = 10,
    localparam int WORDS  = N * N * BITS / BUS_W,
    localparam int CNT_W  = $clog2(WORDS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sel,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [BUS_W-1:0]      i_wr_data,
    output logic [BUS_W-1:0]      o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_load_all,
    input  logic [N*N*BITS-1:0]   i_load_data,
    input  logic                  i_clear,
    output logic [N*N*BITS-1:0]   o_mat_out,
    output logic [CNT_W-1:0]      o_fill_cnt,
    output logic                  o_ready,
    output logic                  o_err
);
    localparam int BPW    = BUS_W / 8;
    localparam int OFF_W  = $clog2(BPW);
    localparam int WIDX_W = ADDR_W - OFF_W;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WIDX_W-1:0] WORDS_W = WIDX_W'(WORDS);
    localparam logic [CNT_W-1:0]  WORDS_C = CNT_W'(WORDS);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BUS_W-1:0]      r_mem [WORDS];
    logic [WORDS-1:0]      r_map;
    logic [CNT_W-1:0]      r_fill_cnt;
    logic [BUS_W-1:0]      r_rd_data;
    logic                  r_rd_valid;
    logic                  r_err;

    logic [WIDX_W-1:0]     w_word;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_ok;
    logic                  w_wr_req;
    logic                  w_rd_req;
    logic                  w_wr_live;
    logic                  w_wr_acc;
    logic                  w_wr_rej;
    logic                  w_new;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [N*N*BITS-1:0]   w_mat;

    assign w_word    = i_addr[ADDR_W-1:OFF_W];
    assign w_idx     = w_word[IDX_W-1:0];
    assign w_ok      = (i_addr[OFF_W-1:0] == '0) && (w_word < WORDS_W);
    assign w_wr_req  = i_sel & i_wr_en;
    assign w_rd_req  = i_sel & i_rd_en;
    // A write that collides with clear or load_all is silently dropped, not flagged.
    assign w_wr_live = w_wr_req & ~i_clear & ~i_load_all;
    assign w_wr_acc  = w_wr_live & (r_state != FULL) & w_ok;
    assign w_wr_rej  = w_wr_live & ~((r_state != FULL) & w_ok);
    // Only first writes to a word advance the fill count.
    assign w_new     = w_wr_acc & ~r_map[w_idx];
    assign w_cnt_nxt = r_fill_cnt + CNT_W'(w_new);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FULL is entered on the same edge that the last new word lands.
    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = EMPTY;
        end else if (i_load_all) begin
            w_state_nxt = FULL;
        end else if (w_wr_acc) begin
            if (w_cnt_nxt == WORDS_C) begin
                w_state_nxt = FULL;
            end else begin
                w_state_nxt = FILLING;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < WORDS; k++) begin
                r_mem[k] <= '0;
            end
            r_map      <= '0;
            r_fill_cnt <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_req;
            r_err      <= w_wr_rej | (w_rd_req & ~w_ok);
            // Read samples storage before this cycle's update, so read-during-write sees old data.
            if (w_rd_req) begin
                r_rd_data <= w_ok ? r_mem[w_idx] : '0;
            end
            if (i_clear) begin
                for (int k = 0; k < WORDS; k++) begin
                    r_mem[k] <= '0;
                end
                r_map      <= '0;
                r_fill_cnt <= '0;
            end else if (i_load_all) begin
                for (int k = 0; k < WORDS; k++) begin
                    r_mem[k] <= i_load_data[k*BUS_W +: BUS_W];
                end
                r_map      <= '1;
                r_fill_cnt <= WORDS_C;
            end else if (w_wr_acc) begin
                r_mem[w_idx] <= i_wr_data;
                r_map[w_idx] <= 1'b1;
                r_fill_cnt   <= w_cnt_nxt;
            end
        end
    end

    always_comb begin
        w_mat = '0;
        for (int k = 0; k < WORDS; k++) begin
            w_mat[k*BUS_W +: BUS_W] = r_mem[k];
        end
    end

    assign o_mat_out  = w_mat;
    assign o_fill_cnt = r_fill_cnt;
    assign o_ready    = (r_state == FULL);
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_err      = r_err;
endmodule

// File: tb/tb_matrix_buffer.sv
module tb_matrix_buffer;
    localparam int N      = 8;
    localparam int BITS   = 8;
    localparam int BUS_W  = 32;
    localparam int ADDR_W = 10;
    localparam int WORDS  = 16;
    localparam int CNT_W  = 5;
    localparam int IMG    = N * N * BITS;

    logic              clk;
    logic              rst;
    logic              sel, wr_en, rd_en, load_all, clear;
    logic [ADDR_W-1:0] addr;
    logic [BUS_W-1:0]  wr_data;
    logic [IMG-1:0]    load_data;
    logic [BUS_W-1:0]  rd_data;
    logic              rd_valid, ready, err;
    logic [IMG-1:0]    mat_out;
    logic [CNT_W-1:0]  fill_cnt;

    matrix_buffer #(.N(N), .BITS(BITS), .BUS_W(BUS_W), .ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_wr_en(wr_en), .i_rd_en(rd_en),
        .i_addr(addr), .i_wr_data(wr_data), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .i_load_all(load_all), .i_load_data(load_data), .i_clear(clear),
        .o_mat_out(mat_out), .o_fill_cnt(fill_cnt), .o_ready(ready), .o_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: plain word array, written-word set and count.
    logic [BUS_W-1:0] m_mem [WORDS];
    bit               m_map [WORDS];
    int               m_cnt;

    task automatic check(input string tag, input logic [IMG-1:0] obs, input logic [IMG-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [IMG-1:0] model_img();
        logic [IMG-1:0] v;
        v = '0;
        for (int k = 0; k < WORDS; k++) v[k*BUS_W +: BUS_W] = m_mem[k];
        return v;
    endfunction

    function automatic bit addr_ok(input int a);
        return (a % 4 == 0) && (a / 4 < WORDS);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < WORDS; k++) begin
            m_mem[k] = '0;
            m_map[k] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic idle();
        sel = 0; wr_en = 0; rd_en = 0; load_all = 0; clear = 0;
        addr = '0; wr_data = '0; load_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_fill_cnt"}, fill_cnt, m_cnt);
        check({tag, "_ready"}, ready, m_cnt == WORDS);
        check({tag, "_mat_out"}, mat_out, model_img());
    endtask

    task automatic wr(input int a, input logic [BUS_W-1:0] d);
        bit acc;
        acc = (m_cnt != WORDS) && addr_ok(a);
        sel = 1; wr_en = 1; addr = a[ADDR_W-1:0]; wr_data = d;
        step();
        idle();
        if (acc) begin
            if (!m_map[a/4]) m_cnt++;
            m_map[a/4] = 1;
            m_mem[a/4] = d;
        end
        check("wr_err", err, !acc);
        check("wr_rd_valid", rd_valid, 1'b0);
        check_status("wr");
    endtask

    task automatic rd(input int a);
        logic [BUS_W-1:0] exp;
        exp = addr_ok(a) ? m_mem[a/4] : '0;
        sel = 1; rd_en = 1; addr = a[ADDR_W-1:0];
        step();
        idle();
        check("rd_valid", rd_valid, 1'b1);
        check("rd_data", rd_data, exp);
        check("rd_err", err, !addr_ok(a));
        step();
        check("rd_valid_pulse", rd_valid, 1'b0);
        check("rd_err_pulse", err, 1'b0);
    endtask

    // Read and write of the same in-range word in one cycle.
    task automatic rw(input int a, input logic [BUS_W-1:0] d);
        logic [BUS_W-1:0] old;
        old = m_mem[a/4];
        sel = 1; rd_en = 1; wr_en = 1; addr = a[ADDR_W-1:0]; wr_data = d;
        step();
        idle();
        if (m_cnt != WORDS) begin
            if (!m_map[a/4]) m_cnt++;
            m_map[a/4] = 1;
            m_mem[a/4] = d;
        end
        check("rw_rd_data", rd_data, old);
        check("rw_rd_valid", rd_valid, 1'b1);
        check_status("rw");
    endtask

    // Clear together with a write and a load: both must be dropped without err.
    task automatic clr();
        clear = 1; load_all = 1; load_data = {IMG{1'b1}};
        sel = 1; wr_en = 1; addr = '0; wr_data = 32'h1234_5678;
        step();
        idle();
        model_reset();
        check("clr_err", err, 1'b0);
        check_status("clr");
    endtask

    task automatic load(input bit with_wr);
        logic [IMG-1:0] img;
        for (int k = 0; k < WORDS; k++) img[k*BUS_W +: BUS_W] = $urandom;
        load_all = 1; load_data = img;
        sel = with_wr; wr_en = with_wr; addr = 10'd12; wr_data = 32'hA5A5_5A5A;
        step();
        idle();
        for (int k = 0; k < WORDS; k++) begin
            m_mem[k] = img[k*BUS_W +: BUS_W];
            m_map[k] = 1;
        end
        m_cnt = WORDS;
        check("load_err", err, 1'b0);
        check("load_image", mat_out, img);
        check_status("load");
    endtask

    initial begin
        logic [BUS_W-1:0] a_val;
        logic [BUS_W-1:0] b_val;
        int               a;
        int               r;

        idle();
        model_reset();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fill_cnt", fill_cnt, '0);
        check("rst_ready", ready, 1'b0);
        check("rst_mat_out", mat_out, '0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rd_data", rd_data, '0);
        #3 rst = 1;
        step();

        // Sequential fill; ready must appear right after the last word.
        for (int k = 0; k < WORDS; k++) wr(4 * k, $urandom);

        // Rewrite counts once; read returns the latest value.
        clr();
        a_val = $urandom;
        b_val = $urandom;
        wr(8, a_val);
        wr(8, b_val);
        rd(8);
        rw(8, $urandom);
        rd(8);

        // Locked when full, then clear.
        for (int k = 0; k < WORDS; k++) wr(4 * k, $urandom);
        wr(0, 32'hDEAD_BEEF);
        rd(0);
        clr();

        // Misaligned and out-of-range accesses.
        wr(4, $urandom);
        wr(6, $urandom);
        wr(64, $urandom);
        rd(64);
        rd(6);

        // Bulk load beats a simultaneous host write.
        load(1);
        wr(20, $urandom);

        // Asynchronous reset mid-fill.
        clr();
        for (int k = 0; k < 7; k++) wr(4 * $urandom_range(0, WORDS - 1), $urandom);
        #2 rst = 0;
        #1;
        model_reset();
        check("arst_fill_cnt", fill_cnt, '0);
        check("arst_ready", ready, 1'b0);
        check("arst_mat_out", mat_out, '0);
        check("arst_rd_data", rd_data, '0);
        #3 rst = 1;
        step();
        wr(12, $urandom);

        // Randomized mix checked against the model.
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 19);
            a = (r % 2 == 0) ? 4 * $urandom_range(0, WORDS - 1) : $urandom_range(0, 70);
            if (r < 11) wr(a, $urandom);
            else if (r < 17) rd(a);
            else if (r < 18) rw(4 * $urandom_range(0, WORDS - 1), $urandom);
            else if (r < 19) clr();
            else load($urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
